mux_tree_reduce_pipe: RTL and testbench
=======================================

MUX_TREE_REDUCE_PIPE -- requirements
Module: mux_tree_reduce_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of input lanes; N is a power of two and at least 2.
REQ-002 The block SHALL have parameter W, default 4, giving the bit width of each lane.
REQ-003 The block SHALL derive constant LEVELS = $clog2(N), which is the pipeline depth.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_data and in_op carry a request.
REQ-007 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 Port in_data, input, N*W bits: the lanes, with lane i at bits [i*W +: W].
REQ-009 Port in_op, input, 2 bits: the reduction operation, of type op_t.
REQ-010 Port out_valid, output, 1 bit: out_data holds a result.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 Port out_data, output, W bits: the bitwise reduction of all N lanes.

Function
REQ-013 The block SHALL compute out_data as the bitwise reduction of the N lanes under in_op:
- 00 AND
- 01 OR
- 10 XOR
- 11 XNOR (the XOR result, inverted once, at the final level)
REQ-014 The block SHALL build every logic function only from 2:1 mux instances, constants 0/1 and wires; no &, |, ^ or ~ operators.
- AND: mux(d0=0, d1=a, sel=b)
- OR: mux(d0=a, d1=1, sel=b)
- NOT: mux(d0=1, d1=0, sel=a)
- XOR: mux(d0=a, d1=NOT a, sel=b)
REQ-015 The reduction SHALL be a balanced binary tree of LEVELS levels; level k combines adjacent pairs and halves the lane count.
REQ-016 The output of every level SHALL be registered, together with a valid bit and the 2-bit op, giving a latency of exactly LEVELS cycles from accept to out_valid when nothing stalls.
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both 1, at both the input and the output.
REQ-018 Stage k SHALL load when it is empty or when stage k+1 loads (for the last stage, when out_ready is 1); otherwise it SHALL hold its contents.
REQ-019 in_ready SHALL equal the load condition of stage 0 and SHALL depend combinationally on out_ready.
REQ-020 Throughput SHALL be one result per cycle while out_ready stays 1.
REQ-021 While out_ready is 0, the block SHALL hold up to LEVELS requests without loss.
REQ-022 While stalled, out_data and out_valid SHALL stay stable.
REQ-023 Bubbles SHALL collapse: an empty stage accepts even while a later stage is stalled.
REQ-024 Results SHALL leave strictly in acceptance order.
REQ-025 Each request SHALL carry its own op, so mixed ops back-to-back give per-request correct results.
REQ-026 When in_valid is 0, the input data SHALL be ignored; no stage loads a valid entry from it.

Reset
REQ-027 While rst is 1 at a clock edge, all stage valid bits SHALL clear to 0, all data and op registers SHALL clear to 0, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-028 While rst is 1, in_ready SHALL be 0.
REQ-029 Any request in flight when rst is asserted SHALL be discarded and SHALL never appear at the output.
REQ-030 The block SHALL accept a new request on the first cycle after rst deasserts.

Structure
REQ-031 Package mux_tree_pkg SHALL hold the op_t enum (OP_AND, OP_OR, OP_XOR, OP_XNOR) and the op width constant.
REQ-032 Sub-module mux2_w SHALL be a W-bit-parameterised 2:1 mux (d0, d1, sel, y), and it SHALL be the only primitive used for the logic.
REQ-033 The tree SHALL be built with generate loops over levels and pairs; there SHALL be no hand-unrolled stages.

Verification (N=4, W=4, LEVELS=2 unless noted)
REQ-034 The bench SHALL cover these directed scenarios:
- AND on lanes {F,E,7,F}, out_ready=1: out_valid 2 cycles later, out_data=6.
- OR on lanes {1,2,4,8}: out_data=F; then XOR on {F,1,2,0} next cycle: out_data=C one cycle after the F.
- Three back-to-back requests with out_ready=0 for 4 cycles: in_ready falls after 2 accepts, out_data stays stable, and the 3 results drain in order once out_ready=1.
- Reset for one cycle with 2 requests in flight: out_valid=0 next cycle and no stale result ever emerges; a new request is accepted the cycle after rst drops.
- N=2, XNOR on {A,C}: out_data=9 after 1 cycle.
- Random ops and data with random out_ready over 10k cycles, checked against a reference-model scoreboard with no loss, duplication or reordering.

Source files
------------

// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - reduction op encoding shared by the mux-only reduction tree
package mux_tree_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_t;

endpackage

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - W-bit 2:1 mux, the sole logic primitive of the reduction tree
module mux2_w #(
  parameter int W = 1
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_tree_reduce_pipe.sv
// rtl/mux_tree_reduce_pipe.sv - pipelined N-lane bitwise AND/OR/XOR/XNOR reduction
// built only from 2:1 muxes, one registered stage per tree level, valid/ready flow control
module mux_tree_reduce_pipe
  import mux_tree_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [1:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data
);

  localparam int LEVELS = $clog2(N);

  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int IN_LANES  = N >> k;
    localparam int OUT_LANES = IN_LANES / 2;

    logic [IN_LANES*W-1:0]  src_data;
    logic [OP_W-1:0]        src_op;
    logic                   src_valid;
    logic                   next_load;
    logic                   load;
    logic [OUT_LANES*W-1:0] comb_data;

    logic                   valid_q, valid_d;
    op_t                    op_q, op_d;
    logic [OUT_LANES*W-1:0] data_q, data_d;

    if (k == 0) begin : g_src
      assign src_data  = in_data;
      assign src_op    = in_op;
      assign src_valid = in_valid;
    end else begin : g_src
      assign src_data  = lvl[k-1].data_q;
      assign src_op    = lvl[k-1].op_q;
      assign src_valid = lvl[k-1].valid_q;
    end

    if (k == LEVELS - 1) begin : g_nxt
      assign next_load = out_ready;
    end else begin : g_nxt
      assign next_load = lvl[k+1].load;
    end

    // An empty stage always loads; a full one only when its successor takes its entry.
    mux2_w #(.W(1)) u_load (.d0(1'b1), .d1(next_load), .sel(valid_q), .y(load));

    for (genvar p = 0; p < OUT_LANES; p++) begin : g_pair
      logic [W-1:0] a, b, and_v, or_v, not_a, xor_v, ao_v;

      assign a = src_data[2*p*W +: W];
      assign b = src_data[(2*p+1)*W +: W];

      for (genvar i = 0; i < W; i++) begin : g_bit
        mux2_w #(.W(1)) u_and (.d0(1'b0), .d1(a[i]),     .sel(b[i]), .y(and_v[i]));
        mux2_w #(.W(1)) u_or  (.d0(a[i]), .d1(1'b1),     .sel(b[i]), .y(or_v[i]));
        mux2_w #(.W(1)) u_not (.d0(1'b1), .d1(1'b0),     .sel(a[i]), .y(not_a[i]));
        mux2_w #(.W(1)) u_xor (.d0(a[i]), .d1(not_a[i]), .sel(b[i]), .y(xor_v[i]));
      end

      // XNOR reduces as XOR through the tree; the inversion happens once at the output.
      mux2_w #(.W(W)) u_sel_ao (.d0(and_v), .d1(or_v),  .sel(src_op[0]), .y(ao_v));
      mux2_w #(.W(W)) u_sel_x  (.d0(ao_v),  .d1(xor_v), .sel(src_op[1]), .y(comb_data[p*W +: W]));
    end

    always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      data_d  = data_q;
      if (load) begin
        valid_d = src_valid;
        if (src_valid) begin
          op_d   = op_t'(src_op);
          data_d = comb_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        op_q    <= OP_AND;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        op_q    <= op_d;
        data_q  <= data_d;
      end
    end
  end

  logic [OP_W-1:0] fin_op;
  logic            fin_inv;
  logic [W-1:0]    fin_data;
  logic [W-1:0]    fin_not;

  assign fin_op   = lvl[LEVELS-1].op_q;
  assign fin_data = lvl[LEVELS-1].data_q;

  mux2_w #(.W(1)) u_inv (.d0(1'b0), .d1(fin_op[1]), .sel(fin_op[0]), .y(fin_inv));

  for (genvar i = 0; i < W; i++) begin : g_fin_not
    mux2_w #(.W(1)) u_not (.d0(1'b1), .d1(1'b0), .sel(fin_data[i]), .y(fin_not[i]));
  end

  mux2_w #(.W(W)) u_fin (.d0(fin_data), .d1(fin_not), .sel(fin_inv), .y(out_data));

  assign out_valid = lvl[LEVELS-1].valid_q;

  mux2_w #(.W(1)) u_rdy (.d0(lvl[0].load), .d1(1'b0), .sel(rst), .y(in_ready));

endmodule

// File: tb/tb_mux_tree_reduce_pipe.sv
// tb/tb_mux_tree_reduce_pipe.sv - directed and scoreboarded checks of the mux reduction pipe
module tb_mux_tree_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [3:0]  out_data;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  in_data2;
  logic [1:0]  in_op2;
  logic [3:0]  out_data2;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb_q[$];
  logic [3:0] exp_v;

  mux_tree_reduce_pipe #(.N(4), .W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  mux_tree_reduce_pipe #(.N(2), .W(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_op(in_op2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_reduce(input logic [15:0] d, input logic [1:0] op);
    logic [3:0] r;
    r = d[3:0];
    for (int i = 1; i < 4; i++) begin
      case (op)
        2'b00:   r = r & d[i*4 +: 4];
        2'b01:   r = r | d[i*4 +: 4];
        default: r = r ^ d[i*4 +: 4];
      endcase
    end
    if (op == 2'b11) r = ~r;
    return r;
  endfunction

  task automatic score_cycle();
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_v = sb_q.pop_front();
        check("sb_data", {28'd0, out_data}, {28'd0, exp_v});
      end
    end
    if (in_valid && in_ready) sb_q.push_back(ref_reduce(in_data, in_op));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_op = 2'b00; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; in_op2 = 2'b00; out_ready2 = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_out_valid_n2", {31'd0, out_valid2}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    #1 check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // AND, latency 2
    in_valid = 1'b1; in_data = 16'hFE7F; in_op = 2'b00;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'hFFFF;
    check("and_lat1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("and_valid", {31'd0, out_valid}, 32'd1);
    check("and_data", {28'd0, out_data}, 32'h6);
    @(negedge clk);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // OR then XOR back-to-back
    in_valid = 1'b1; in_data = 16'h8421; in_op = 2'b01;
    @(negedge clk);
    in_data = 16'h021F; in_op = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    check("or_valid", {31'd0, out_valid}, 32'd1);
    check("or_data", {28'd0, out_data}, 32'hF);
    @(negedge clk);
    check("xor_valid", {31'd0, out_valid}, 32'd1);
    check("xor_data", {28'd0, out_data}, 32'hC);
    @(negedge clk);
    check("bb_idle", {31'd0, out_valid}, 32'd0);

    // stall with three back-to-back requests
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hFE7F; in_op = 2'b00;
    #1 check("st_rdy_a", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_data = 16'h8421; in_op = 2'b01;
    #1 check("st_rdy_b", {31'd0, in_ready}, 32'd1);
    check("st_valid_b", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_data = 16'h021F; in_op = 2'b10;
    #1 check("st_rdy_c", {31'd0, in_ready}, 32'd0);
    check("st_valid_c", {31'd0, out_valid}, 32'd1);
    check("st_data_c", {28'd0, out_data}, 32'h6);
    @(negedge clk);
    check("st_rdy_d", {31'd0, in_ready}, 32'd0);
    check("st_data_d", {28'd0, out_data}, 32'h6);
    @(negedge clk);
    check("st_valid_e", {31'd0, out_valid}, 32'd1);
    check("st_data_e", {28'd0, out_data}, 32'h6);
    out_ready = 1'b1;
    #1 check("st_rdy_release", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("drain_1", {28'd0, out_data}, 32'hF);
    check("drain_1_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("drain_2", {28'd0, out_data}, 32'hC);
    check("drain_2_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("drain_idle", {31'd0, out_valid}, 32'd0);

    // reset with two requests in flight
    in_valid = 1'b1; in_data = 16'hFE7F; in_op = 2'b00;
    @(negedge clk);
    in_data = 16'h8421; in_op = 2'b01;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("rst_fl_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rst_fl_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fl_data", {28'd0, out_data}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'h021F; in_op = 2'b10;
    #1 check("rst_fl_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_fl_no_stale", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("rst_fl_new_valid", {31'd0, out_valid}, 32'd1);
    check("rst_fl_new_data", {28'd0, out_data}, 32'hC);
    @(negedge clk);
    check("rst_fl_idle", {31'd0, out_valid}, 32'd0);

    // N=2 XNOR, latency 1
    in_valid2 = 1'b1; in_data2 = 8'hCA; in_op2 = 2'b11;
    #1 check("n2_ready", {31'd0, in_ready2}, 32'd1);
    @(negedge clk);
    in_valid2 = 1'b0;
    check("n2_valid", {31'd0, out_valid2}, 32'd1);
    check("n2_xnor", {28'd0, out_data2}, 32'h9);
    @(negedge clk);
    check("n2_idle", {31'd0, out_valid2}, 32'd0);

    // random traffic against the reference scoreboard
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_op     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1 score_cycle();
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1 score_cycle();
    end
    check("sb_drained", sb_q.size(), 32'd0);
    check("sb_final_idle", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
